// File: rtl/ysyx_22040750_pipe_stage_reg_if.sv
// Purpose : one valid/allowin handshake channel carrying an opaque DATA_W-bit payload.
// Ports   : valid/data flow from master to slave, allowin flows back from slave to master.
// Modports: master = producer side, slave = consumer side.
interface ysyx_22040750_pipe_stage_reg_if #(
  parameter int DATA_W = 64
);
  logic              valid;
  logic              allowin;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input allowin);
  modport slave  (input valid, input data, output allowin);
endinterface

// File: rtl/ysyx_22040750_pipe_stage_reg.sv
// Purpose : generic pipeline stage register with flush and an optional two-entry skid mode.
// Ports   : I_sys_clk/I_rst_n/I_flush scalars, up (slave channel), dn (master channel), O_count.
// Timing  : one-cycle latency when empty; SKID=0 allowin is combinational, SKID=1 allowin is registered.
module ysyx_22040750_pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int SKID   = 0
) (
  input  logic                                  I_sys_clk,
  input  logic                                  I_rst_n,
  input  logic                                  I_flush,
  ysyx_22040750_pipe_stage_reg_if.slave         up,
  ysyx_22040750_pipe_stage_reg_if.master        dn,
  output logic [1:0]                            O_count
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic              main_valid;
  logic              skid_valid;
  logic [DATA_W-1:0] main_q;
  logic              in_fire;
  logic              out_fire;

  // A flush cycle accepts nothing and hands nothing downstream.
  assign in_fire  = up.valid && up.allowin && !I_flush;
  assign out_fire = dn.valid && dn.allowin;

  assign dn.valid = main_valid && !I_flush;
  assign dn.data  = main_q;
  assign O_count  = skid_valid ? FULL : (main_valid ? ONE : EMPTY);

  if (SKID == 0) begin : g_single
    assign skid_valid = 1'b0;
    // Slot frees up in the same cycle the current entry leaves.
    assign up.allowin = !main_valid || dn.allowin;

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        main_valid <= 1'b0;
        main_q     <= '0;
      end else if (I_flush) begin
        main_valid <= 1'b0;
      end else if (in_fire) begin
        main_valid <= 1'b1;
        main_q     <= up.data;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end
    end
  end else begin : g_skid
    logic              skid_valid_q;
    logic [DATA_W-1:0] skid_q;

    assign skid_valid = skid_valid_q;
    // Registered ready: the skid slot absorbs the one payload that may
    // arrive after downstream stalls, so no path from dn.allowin is needed.
    assign up.allowin = !skid_valid_q;

    always_ff @(posedge I_sys_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
        main_valid   <= 1'b0;
        skid_valid_q <= 1'b0;
        main_q       <= '0;
        skid_q       <= '0;
      end else if (I_flush) begin
        main_valid   <= 1'b0;
        skid_valid_q <= 1'b0;
      end else begin
        case (O_count)
          EMPTY: begin
            if (in_fire) begin
              main_valid <= 1'b1;
              main_q     <= up.data;
            end
          end
          ONE: begin
            if (in_fire && out_fire) begin
              main_q <= up.data;
            end else if (in_fire) begin
              skid_valid_q <= 1'b1;
              skid_q       <= up.data;
            end else if (out_fire) begin
              main_valid <= 1'b0;
            end
          end
          FULL: begin
            // Older entry leaves; the skid entry moves up to keep ordering.
            if (out_fire) begin
              skid_valid_q <= 1'b0;
              main_q       <= skid_q;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_pipe_stage_reg.sv
// Bench for ysyx_22040750_pipe_stage_reg: four builds side by side
// (0: SKID=0/W64, 1: SKID=1/W64, 2: SKID=1/W128, 3: SKID=0/W1).
module tb_ysyx_22040750_pipe_stage_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         flush;
  logic [3:0]   in_vld;
  logic [3:0]   ao;
  logic [127:0] in_dat [4];

  logic [3:0]   o_vld;
  logic [3:0]   o_alw;
  logic [1:0]   o_cnt [4];
  logic [127:0] o_dat [4];

  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(64))  u0 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(64))  d0 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(64))  u1 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(64))  d1 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(128)) u2 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(128)) d2 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(1))   u3 ();
  ysyx_22040750_pipe_stage_reg_if #(.DATA_W(1))   d3 ();

  assign u0.valid = in_vld[0];  assign u0.data = in_dat[0][63:0];
  assign u1.valid = in_vld[1];  assign u1.data = in_dat[1][63:0];
  assign u2.valid = in_vld[2];  assign u2.data = in_dat[2];
  assign u3.valid = in_vld[3];  assign u3.data = in_dat[3][0];
  assign d0.allowin = ao[0];
  assign d1.allowin = ao[1];
  assign d2.allowin = ao[2];
  assign d3.allowin = ao[3];

  assign o_vld = {d3.valid, d2.valid, d1.valid, d0.valid};
  assign o_alw = {u3.allowin, u2.allowin, u1.allowin, u0.allowin};
  assign o_dat[0] = {64'd0, d0.data};
  assign o_dat[1] = {64'd0, d1.data};
  assign o_dat[2] = d2.data;
  assign o_dat[3] = {127'd0, d3.data};

  ysyx_22040750_pipe_stage_reg #(.DATA_W(64), .SKID(0)) dut0 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(flush), .up(u0.slave), .dn(d0.master), .O_count(o_cnt[0]));
  ysyx_22040750_pipe_stage_reg #(.DATA_W(64), .SKID(1)) dut1 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(flush), .up(u1.slave), .dn(d1.master), .O_count(o_cnt[1]));
  ysyx_22040750_pipe_stage_reg #(.DATA_W(128), .SKID(1)) dut2 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(flush), .up(u2.slave), .dn(d2.master), .O_count(o_cnt[2]));
  ysyx_22040750_pipe_stage_reg #(.DATA_W(1), .SKID(0)) dut3 (
    .I_sys_clk(clk), .I_rst_n(rst_n), .I_flush(flush), .up(u3.slave), .dn(d3.master), .O_count(o_cnt[3]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int inst, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got=%h want=%h", nm, inst, act, exp);
    end
  endtask

  // ---------------- reference model: a FIFO of capacity 1 or 2 per build ----------------
  int           mcnt [4];
  logic [127:0] mdat [4][2];
  logic [3:0]   m_it;
  logic [3:0]   m_ot;

  function automatic int cap(input int i);
    return (i == 1 || i == 2) ? 2 : 1;
  endfunction

  function automatic logic [127:0] wmask(input int i);
    logic [127:0] m;
    if (i == 2)      m = '1;
    else if (i == 3) m = 128'd1;
    else             m = {64'd0, {64{1'b1}}};
    return m;
  endfunction

  // Room exists if not at capacity; a single slot can also be reused when it drains this cycle.
  function automatic logic exp_allow(input int i);
    return (mcnt[i] < cap(i)) || (cap(i) == 1 && ao[i]);
  endfunction

  task automatic model_check_and_plan();
    for (int i = 0; i < 4; i++) begin
      logic ev;
      ev = (mcnt[i] > 0) && !flush;
      chk("allowin", i, {127'd0, o_alw[i]}, {127'd0, exp_allow(i)});
      chk("valid",   i, {127'd0, o_vld[i]}, {127'd0, ev});
      chk("count",   i, {126'd0, o_cnt[i]}, 128'(mcnt[i]));
      if (ev) chk("data", i, o_dat[i], mdat[i][0]);
      m_it[i] = in_vld[i] && exp_allow(i) && !flush;
      m_ot[i] = ev && ao[i];
    end
  endtask

  task automatic model_apply(input logic fl);
    for (int i = 0; i < 4; i++) begin
      if (fl) begin
        mcnt[i] = 0;
      end else begin
        if (m_ot[i]) begin
          mdat[i][0] = mdat[i][1];
          mcnt[i]--;
        end
        if (m_it[i]) begin
          mdat[i][mcnt[i]] = in_dat[i] & wmask(i);
          mcnt[i]++;
        end
      end
    end
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    int           inst;
    logic         vld;
    logic [127:0] dat;
    logic         ao;
    logic         fl;
    logic         e_alw;
    logic         e_vld;
    logic         chk_dat;
    logic [127:0] e_dat;
    logic [1:0]   e_cnt;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input int inst, input logic vld, input logic [127:0] dat, input logic a, input logic fl,
                     input logic e_alw, input logic e_vld, input logic chk_dat, input logic [127:0] e_dat,
                     input logic [1:0] e_cnt);
    vec_t v;
    v.inst = inst; v.vld = vld; v.dat = dat; v.ao = a; v.fl = fl;
    v.e_alw = e_alw; v.e_vld = e_vld; v.chk_dat = chk_dat; v.e_dat = e_dat; v.e_cnt = e_cnt;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    in_vld = '0;
    ao     = '1;
    flush  = 1'b0;
    for (int i = 0; i < 4; i++) in_dat[i] = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) mcnt[i] = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    for (int i = 0; i < 4; i++) begin
      chk("rst_valid",   i, {127'd0, o_vld[i]}, 128'd0);
      chk("rst_data",    i, o_dat[i], 128'd0);
      chk("rst_count",   i, {126'd0, o_cnt[i]}, 128'd0);
      chk("rst_allowin", i, {127'd0, o_alw[i]}, 128'd1);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // SKID=1: back-pressure then in-order drain
    add(1, 1, 128'hA, 0, 0, 1, 0, 0, 0,      0);
    add(1, 1, 128'hB, 0, 0, 1, 1, 1, 128'hA, 1);
    add(1, 1, 128'hC, 0, 0, 0, 1, 1, 128'hA, 2);
    add(1, 0, 0,      1, 0, 0, 1, 1, 128'hA, 2);
    add(1, 0, 0,      1, 0, 1, 1, 1, 128'hB, 1);
    add(1, 0, 0,      1, 0, 1, 0, 0, 0,      0);
    // SKID=1: flush while full, incoming payload discarded, data regs untouched
    add(1, 1, 128'hD, 0, 0, 1, 0, 0, 0,      0);
    add(1, 1, 128'hE, 0, 0, 1, 1, 1, 128'hD, 1);
    add(1, 1, 128'hF, 1, 1, 0, 0, 0, 0,      2);
    add(1, 0, 0,      1, 0, 1, 0, 1, 128'hD, 0);
    add(1, 1, 128'h7, 1, 0, 1, 0, 0, 0,      0);
    add(1, 1, 128'h8, 1, 0, 1, 1, 1, 128'h7, 1);
    add(1, 0, 0,      1, 0, 1, 1, 1, 128'h8, 1);
    add(1, 0, 0,      1, 0, 1, 0, 1, 128'h8, 0);
    // SKID=0: stall, replace-on-drain, bubble holds data, flush discards
    add(0, 1, 128'h5, 0, 0, 1, 0, 0, 0,      0);
    add(0, 1, 128'h6, 0, 0, 0, 1, 1, 128'h5, 1);
    add(0, 1, 128'h6, 1, 0, 1, 1, 1, 128'h5, 1);
    add(0, 0, 0,      0, 0, 0, 1, 1, 128'h6, 1);
    add(0, 0, 0,      1, 0, 1, 1, 1, 128'h6, 1);
    add(0, 0, 0,      0, 0, 1, 0, 1, 128'h6, 0);
    add(0, 1, 128'h9, 1, 1, 1, 0, 0, 0,      0);
    add(0, 0, 0,      1, 0, 1, 0, 1, 128'h6, 0);

    foreach (tbl[k]) begin
      idle_inputs();
      in_vld[tbl[k].inst] = tbl[k].vld;
      in_dat[tbl[k].inst] = tbl[k].dat;
      ao[tbl[k].inst]     = tbl[k].ao;
      flush               = tbl[k].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_allowin", k), tbl[k].inst, {127'd0, o_alw[tbl[k].inst]}, {127'd0, tbl[k].e_alw});
      chk($sformatf("vec%0d_valid", k),   tbl[k].inst, {127'd0, o_vld[tbl[k].inst]}, {127'd0, tbl[k].e_vld});
      chk($sformatf("vec%0d_count", k),   tbl[k].inst, {126'd0, o_cnt[tbl[k].inst]}, {126'd0, tbl[k].e_cnt});
      if (tbl[k].chk_dat)
        chk($sformatf("vec%0d_data", k),  tbl[k].inst, o_dat[tbl[k].inst], tbl[k].e_dat);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset with entries in flight (build 1 full, build 0 holding one)
    idle_inputs();
    ao = 4'b0000;
    in_vld[0] = 1'b1; in_dat[0] = 128'h55;
    in_vld[1] = 1'b1; in_dat[1] = 128'hA;
    @(posedge clk);
    #1;
    in_vld[0] = 1'b0;
    in_dat[1] = 128'hB;
    @(posedge clk);
    #1;
    in_vld = '0;
    @(negedge clk);
    chk("pre_rst_count", 1, {126'd0, o_cnt[1]}, 128'd2);
    chk("pre_rst_count", 0, {126'd0, o_cnt[0]}, 128'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("arst_valid",   i, {127'd0, o_vld[i]}, 128'd0);
      chk("arst_data",    i, o_dat[i], 128'd0);
      chk("arst_count",   i, {126'd0, o_cnt[i]}, 128'd0);
      chk("arst_allowin", i, {127'd0, o_alw[i]}, 128'd1);
    end
    #4;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming at full rate, both modes
    idle_inputs();
    for (int n = 1; n <= 6; n++) begin
      in_vld[0] = 1'b1; in_dat[0] = 128'(n);
      in_vld[1] = 1'b1; in_dat[1] = 128'(n);
      @(negedge clk);
      if (n > 1) begin
        for (int i = 0; i < 2; i++) begin
          chk("stream_valid",   i, {127'd0, o_vld[i]}, 128'd1);
          chk("stream_data",    i, o_dat[i], 128'(n - 1));
          chk("stream_count",   i, {126'd0, o_cnt[i]}, 128'd1);
          chk("stream_allowin", i, {127'd0, o_alw[i]}, 128'd1);
        end
      end
      @(posedge clk);
      #1;
    end

    // Randomized traffic against the FIFO model on all four builds
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        in_vld[i] = ($urandom_range(0, 9) < 7);
        ao[i]     = ($urandom_range(0, 9) < 6);
        in_dat[i] = {$urandom, $urandom, $urandom, $urandom};
      end
      flush = ($urandom_range(0, 31) == 0);
      @(negedge clk);
      model_check_and_plan();
      @(posedge clk);
      model_apply(flush);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
